// File: rtl/multicycle_datapath.sv
// Datapath for the multicycle MIPS core: PC, IR, data/A/B/ALUOut registers,
// 32x32 register file and ALU, steered entirely by the controller's strobes.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic        irwrite,
    input  logic        regwrite,
    input  logic        alusrca,
    input  logic        iord,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic [1:0]  alusrcb,
    input  logic [1:0]  pcsrc,
    input  logic [3:0]  alucontrol,
    input  logic [31:0] readdata,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        zero,
    output logic [31:0] adr,
    output logic [31:0] writedata
);

    logic [31:0] pc, ir, data, a, b, aluout;
    logic [31:0] rf [0:31];

    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd;
    logic [31:0] signimm, srca, srcb, alu_result, pc_next;

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        sign_ext = {{16{imm[15]}}, imm};
    endfunction

    // Carry and overflow are discarded; SLT compares as two's complement.
    function automatic logic [31:0] alu(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] ctl);
        logic signed [31:0] xs, ys;
        xs = x;
        ys = y;
        case (ctl)
            4'b0000: alu = x & y;
            4'b0001: alu = x | y;
            4'b0010: alu = x + y;
            4'b0110: alu = x - y;
            4'b0111: alu = (xs < ys) ? 32'd1 : 32'd0;
            4'b1100: alu = ~(x | y);
            default: alu = 32'd0;
        endcase
    endfunction

    assign ra1 = ir[25:21];
    assign ra2 = ir[20:16];
    assign wa  = regdst ? ir[15:11] : ir[20:16];
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];
    assign wd  = memtoreg ? data : aluout;

    assign signimm = sign_ext(ir[15:0]);

    always_comb begin
        srca = alusrca ? a : pc;
        srcb = b;
        case (alusrcb)
            2'b00: srcb = b;
            2'b01: srcb = 32'd4;
            2'b10: srcb = signimm;
            2'b11: srcb = {signimm[29:0], 2'b00};
            default: srcb = b;
        endcase
    end

    assign alu_result = alu(srca, srcb, alucontrol);
    assign zero       = (alu_result == 32'd0);

    always_comb begin
        pc_next = alu_result;
        case (pcsrc)
            2'b01: pc_next = aluout;
            2'b10: pc_next = {pc[31:28], ir[25:0], 2'b00};
            default: pc_next = alu_result;
        endcase
    end

    // State update: reset wins over every enable, including the RF write.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= 32'd0;
            data   <= 32'd0;
            a      <= 32'd0;
            b      <= 32'd0;
            aluout <= 32'd0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else begin
            if (pcen)    pc <= pc_next;
            if (irwrite) ir <= readdata;
            data   <= readdata;
            a      <= rd1;
            b      <= rd2;
            aluout <= alu_result;
            if (regwrite && (wa != 5'd0)) rf[wa] <= wd;
        end
    end

    assign op        = ir[31:26];
    assign funct     = ir[5:0];
    assign adr       = iord ? aluout : pc;
    assign writedata = b;

endmodule
